// File: rtl/sbox_lane_pipe.sv
// rtl/sbox_lane_pipe.sv - pipelined multi-lane AES SubBytes engine; inverse S-box per beat when SBOX_INV_EN is defined
module sbox_lane_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy,
    output logic [15:0]        beat_cnt
);

    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Mode actually applied to the beat; forced to forward when the inverse table is not built.
    logic mode;

`ifdef SBOX_INV_EN
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign mode = in_inv;
`else
    logic unused_in_inv;

    assign mode          = 1'b0;
    assign unused_in_inv = in_inv;
`endif

    logic [8*LANES-1:0] sub_data;
    logic [STAGES-1:0]  v;
    logic [STAGES-1:0]  inv_q;
    logic [STAGES-1:0]  stage_rdy;
    logic [8*LANES-1:0] data_q [STAGES];
    logic [TAG_W-1:0]   tag_q  [STAGES];

    // Per-lane table lookup feeding stage 0; lanes are fully independent.
    always_comb begin
        sub_data = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef SBOX_INV_EN
            sub_data[8*i +: 8] = mode ? INV_SBOX[in_data[8*i +: 8]] : FWD_SBOX[in_data[8*i +: 8]];
`else
            sub_data[8*i +: 8] = FWD_SBOX[in_data[8*i +: 8]];
`endif
        end
    end

    // Stage k may load when any stage at or after it is empty, or the sink takes the last beat;
    // written in closed form so the ready chain is not a self-referencing vector.
    always_comb begin
        stage_rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_rdy[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!v[j]) begin
                    stage_rdy[k] = 1'b1;
                end
            end
        end
    end

    // Elastic pipeline advance plus output-transfer counter; reset flushes every in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v        <= '0;
            inv_q    <= '0;
            beat_cnt <= 16'd0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            if (stage_rdy[0]) begin
                v[0]      <= in_valid;
                data_q[0] <= sub_data;
                tag_q[0]  <= in_tag;
                inv_q[0]  <= mode;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (stage_rdy[k]) begin
                    v[k]      <= v[k-1];
                    data_q[k] <= data_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                    inv_q[k]  <= inv_q[k-1];
                end
            end
            if (out_valid && out_ready) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    assign in_ready  = stage_rdy[0];
    assign out_valid = v[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_inv   = inv_q[STAGES-1];
    assign busy      = |v;

endmodule

// File: tb/tb_sbox_lane_pipe.sv
// tb/tb_sbox_lane_pipe.sv - self-checking bench for sbox_lane_pipe (4-lane/2-stage and 16-lane/1-stage)
module tb_sbox_lane_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_a, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv, a_busy;
    logic [31:0] a_in_data, a_out_data;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [15:0] a_beat_cnt;

    logic         rst_b, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv, b_busy;
    logic [127:0] b_in_data, b_out_data;
    logic [3:0]   b_in_tag, b_out_tag;
    logic [15:0]  b_beat_cnt;

    sbox_lane_pipe #(.LANES(4), .STAGES(2), .TAG_W(4)) u_a (
        .clk(clk), .rst(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_inv(a_in_inv), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_inv(a_out_inv), .out_tag(a_out_tag), .busy(a_busy), .beat_cnt(a_beat_cnt)
    );

    sbox_lane_pipe #(.LANES(16), .STAGES(1), .TAG_W(4)) u_b (
        .clk(clk), .rst(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_inv(b_in_inv), .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_inv(b_out_inv), .out_tag(b_out_tag), .busy(b_busy), .beat_cnt(b_beat_cnt)
    );

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    logic [7:0] got     [256];

    typedef struct packed {
        logic [31:0] data;
        logic        inv;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb_a[$];
    int   cnt_a = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] s;
        if (a == 8'h00) r = 8'h00;
        else for (int i = 0; i < 254; i++) r = gmul(r, a);
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] ref4(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of instance A: drive, check against the scoreboard, record transfers, advance.
    task automatic cycle_a(input logic iv, input logic [31:0] d, input logic inv, input logic [3:0] tg,
                           input logic ordy, output logic acc);
        exp_t e;
        logic eff;
        check("a_beat_cnt", 128'(a_beat_cnt), 128'(cnt_a));
        a_in_valid  = iv;
        a_in_data   = d;
        a_in_inv    = inv;
        a_in_tag    = tg;
        a_out_ready = ordy;
        #1;
        check("a_in_ready", 128'(a_in_ready), 128'((sb_a.size() < 2) || ordy));
        check("a_busy", 128'(a_busy), 128'(sb_a.size() != 0));
        if (a_out_valid) begin
            if (sb_a.size() == 0) begin
                check("a_out_valid_idle", 128'(a_out_valid), 128'(0));
            end else begin
                check("a_out_data", 128'(a_out_data), 128'(sb_a[0].data));
                check("a_out_tag", 128'(a_out_tag), 128'(sb_a[0].tag));
                check("a_out_inv", 128'(a_out_inv), 128'(sb_a[0].inv));
                if (ordy) begin
                    void'(sb_a.pop_front());
                    cnt_a = (cnt_a + 1) & 16'hFFFF;
                end
            end
        end
        acc = iv && a_in_ready;
        if (acc) begin
`ifdef SBOX_INV_EN
            eff = inv;
`else
            eff = 1'b0;
`endif
            e.data = ref4(d, eff);
            e.inv  = eff;
            e.tag  = tg;
            sb_a.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain_a(input string tag);
        logic acc;
        for (int c = 0; c < 10 && sb_a.size() != 0; c++) cycle_a(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, acc);
        check(tag, 128'(sb_a.size()), 128'(0));
    endtask

    initial begin
        logic acc;
        int   nxt;
        int   n;

        for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_ref(8'(i));
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        a_in_valid = 0; a_in_data = 0; a_in_inv = 0; a_in_tag = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_in_inv = 0; b_in_tag = 0; b_out_ready = 0;
        rst_a = 1; rst_b = 1;
        repeat (2) @(negedge clk);
        rst_a = 0; rst_b = 0;

        check("rst_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_busy", 128'(a_busy), 128'(0));
        check("rst_beat_cnt", 128'(a_beat_cnt), 128'(0));
        check("rst_out_data", 128'(a_out_data), 128'(0));
        check("rst_out_tag", 128'(a_out_tag), 128'(0));
        check("rst_out_inv", 128'(a_out_inv), 128'(0));
        check("rst_in_ready", 128'(a_in_ready), 128'(1));

        // Directed forward vector and two-cycle latency.
        cycle_a(1'b1, 32'h01FF5300, 1'b0, 4'h3, 1'b0, acc);
        check("lat_cycle1", 128'(a_out_valid), 128'(0));
        cycle_a(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, acc);
        check("lat_cycle2", 128'(a_out_valid), 128'(1));
        check("fwd_vec_data", 128'(a_out_data), 128'(32'h7C16ED63));
        check("fwd_vec_tag", 128'(a_out_tag), 128'(4'h3));
        cycle_a(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, acc);
        check("fwd_vec_cnt", 128'(a_beat_cnt), 128'(1));

`ifdef SBOX_INV_EN
        // Alternating inverse/forward beats back-to-back.
        cycle_a(1'b1, 32'h7C16ED63, 1'b1, 4'h5, 1'b1, acc);
        cycle_a(1'b1, 32'h01FF5300, 1'b0, 4'h6, 1'b1, acc);
        check("inv_vec_data", 128'(a_out_data), 128'(32'h01FF5300));
        check("inv_vec_inv", 128'(a_out_inv), 128'(1));
        cycle_a(1'b1, 32'h7C16ED63, 1'b1, 4'h7, 1'b1, acc);
        check("alt_fwd_data", 128'(a_out_data), 128'(32'h7C16ED63));
        check("alt_fwd_inv", 128'(a_out_inv), 128'(0));
        drain_a("alt_drain");
`endif

        // Backpressure: six tagged beats, sink stalled on cycles 3..7.
        nxt = 0;
        for (int c = 0; c < 30 && (nxt < 6 || sb_a.size() != 0); c++) begin
            cycle_a(nxt < 6, $urandom, 1'b0, nxt[3:0], !(c >= 3 && c <= 7), acc);
            if (acc) nxt++;
        end
        check("bp_accepted", 128'(nxt), 128'(6));
        check("bp_drained", 128'(sb_a.size()), 128'(0));

        // Bubble fill with the sink stalled.
        for (int c = 0; c < 6; c++) cycle_a((c % 2) == 0, $urandom, 1'b0, 4'(8 + c), 1'b0, acc);
        check("bubble_full", 128'(a_in_ready), 128'(0));
        drain_a("bubble_drain");

        // Randomized traffic with random modes and sink stalls.
        for (int c = 0; c < 300; c++) begin
            cycle_a($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, acc);
        end
        drain_a("rand_drain");

        // Reset with two beats in flight; input offered during reset must be ignored.
        cycle_a(1'b1, 32'h11223344, 1'b0, 4'h1, 1'b0, acc);
        cycle_a(1'b1, 32'h55667788, 1'b0, 4'h2, 1'b0, acc);
        a_in_valid = 1'b1;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        a_in_valid = 1'b0;
        sb_a.delete();
        cnt_a = 0;
        check("midrst_out_valid", 128'(a_out_valid), 128'(0));
        check("midrst_busy", 128'(a_busy), 128'(0));
        check("midrst_beat_cnt", 128'(a_beat_cnt), 128'(0));
        check("midrst_out_data", 128'(a_out_data), 128'(0));
        a_out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("midrst_no_stale", 128'(a_out_valid), 128'(0));
        end

        // 16-lane exhaustive forward coverage, one stage.
        b_out_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            b_in_valid = 1'b1;
            for (int i = 0; i < 16; i++) b_in_data[8*i +: 8] = 8'(16 * b + i);
            @(negedge clk);
            check("b_out_valid", 128'(b_out_valid), 128'(1));
            for (int i = 0; i < 16; i++) begin
                got[16 * b + i] = b_out_data[8*i +: 8];
                check("b_lane", 128'(b_out_data[8*i +: 8]), 128'(fwd_tab[16 * b + i]));
            end
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_cnt16", 128'(b_beat_cnt), 128'(16));
        check("b_sbox_00", 128'(got[8'h00]), 128'(8'h63));
        check("b_sbox_53", 128'(got[8'h53]), 128'(8'hED));
        check("b_sbox_ff", 128'(got[8'hFF]), 128'(8'h16));

        // Counter wrap after 65536 transfers.
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("b_wrap_rst", 128'(b_beat_cnt), 128'(0));
        b_in_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 70000 && n < 65536; c++) begin
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                n++;
                if (n == 65536) check("b_cnt_ffff", 128'(b_beat_cnt), 128'(16'hFFFF));
            end
        end
        check("b_wrap_xfers", 128'(n), 128'(65536));
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_wrap_zero", 128'(b_beat_cnt), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sbox_lane_pipe.md
Name: sbox_lane_pipe

Overview:
- Parametrised, pipelined AES SubBytes engine that substitutes LANES bytes per beat.
- Successor to the single-byte combinational S-box; adds a multi-lane datapath, an elastic valid/ready pipeline of configurable depth, a pass-through sideband tag and an optional inverse mode.
- Sits between the round-key-add stage and ShiftRows in the AES datapath of the hybrid cipher core.
- LANES=4 serves key expansion (SubWord); LANES=16 serves a full-state round.

Parameters:
- LANES, 4, number of byte lanes per beat (1..16).
- STAGES, 2, pipeline register stages (1..4). Stage 1 registers the S-box lookup; later stages are pure retiming registers.
- TAG_W, 4, width of the sideband tag carried alongside the data (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  engine accepts the beat this cycle.
- in_data  input  8*LANES  bytes; lane i = bits [8i+7:8i].
- in_inv  input  1  1 = inverse S-box for this beat; only meaningful with SBOX_INV_EN.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8*LANES  substituted bytes, lane-aligned with in_data.
- out_inv  output  1  mode the beat was processed with.
- out_tag  output  TAG_W  tag of the beat.
- busy  output  1  any stage holds a valid beat.
- beat_cnt  output  16  count of completed output transfers; wraps 0xFFFF->0x0000.

Behaviour:
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Lanes: each lane substitutes independently using the standard AES forward S-box, or the inverse S-box when in_inv=1 and inverse support is compiled in. Lanes share no logic state.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stalls.
- Throughput: one beat per cycle sustained.
- Pipeline control:
  - Stage k holds v[k] plus data/inv/tag.
  - Stage k loads from stage k-1 when (!v[k] || ready[k+1]).
  - ready[STAGES+1] = out_ready.
  - in_ready = !v[1] || ready[2] (combinational path from out_ready; no skid buffer).
  - A bubble is absorbed by the first empty stage: the upstream side keeps accepting while a downstream gap exists.
- Stall:
  - With out_valid=1 and out_ready=0, out_data/out_inv/out_tag hold stable.
  - No beat is dropped or duplicated.
- Ordering: strictly in-order; each tag emerges paired with its own data.
- Data registers: unconditionally loaded when the stage loads, so contents of invalid stages are don't-care.
- out_valid: equals v[STAGES].
- busy: OR of all v[k].
- beat_cnt: increments by 1 per output transfer, saturation-free wrap.
- Reset (rst=1 at a clock edge):
  - All v[k]=0, so out_valid=0 and busy=0.
  - beat_cnt=0.
  - in_ready=1 from the following cycle.
  - out_data/out_tag/out_inv=0.
  - Reset mid-operation discards all in-flight beats; nothing emerges afterward.
  - in_valid during rst is ignored.
- Simultaneous input and output transfer on a full pipe: the pipe stays full and all stages advance by one.
- Simultaneous mode mix: consecutive beats may alternate in_inv; each beat uses its own mode, with no flush or bubble.

Optional Feature:
- Macro SBOX_INV_EN.
- Defined:
  - The inverse S-box table is instantiated per lane.
  - in_inv selects forward or inverse per beat.
  - out_inv = registered in_inv.
- Undefined:
  - Only the forward table exists.
  - in_inv is ignored and out_inv is tied 0.
  - Area roughly halves.

Test Plan:
- Forward, LANES=4, STAGES=2: beat in_data=0x01FF5300, in_inv=0, tag=0x3 -> two cycles later out_data=0x7C16ED63, out_tag=0x3; beat_cnt=1 after the transfer.
- Inverse (SBOX_INV_EN): in_data=0x7C16ED63, in_inv=1 -> out_data=0x01FF5300, out_inv=1. Alternating fwd/inv beats back-to-back each map correctly with no bubble.
- Backpressure: stream 6 beats (tags 0..5) with out_ready low for cycles 3..7.
  - in_ready falls once both stages are full.
  - Outputs are held stable while stalled.
  - All 6 emerge in order, tags 0..5, none lost.
- Bubble fill: out_ready=0, in_valid pulsed on alternate cycles -> pipe fills to STAGES beats; in_ready stays 1 until all stages are valid.
- Reset mid-flight: 2 beats in flight, assert rst one cycle -> out_valid=0, busy=0, beat_cnt=0; no stale beat appears in the next 10 cycles.
- Exhaustive/wrap: LANES=16, STAGES=1.
  - Push 16 beats covering bytes 0x00..0xFF; check every lane against the golden forward table (e.g. 0x53->0xED, 0xFF->0x16).
  - Preload beat_cnt path with 65536 transfers -> beat_cnt wraps to 0.
